// File: rtl/spi_ram_pkg.sv
// Shared opcode and state encodings for the SPI command-decoded burst RAM.
package spi_ram_pkg;

    typedef enum logic [1:0] {
        OP_WR_ADDR = 2'b00,
        OP_WR_DATA = 2'b01,
        OP_RD_ADDR = 2'b10,
        OP_RD_DATA = 2'b11
    } op_e;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

endpackage

// File: rtl/spi_ram_mem.sv
// Single-port synchronous RAM with write enable and a read-enabled output register.
module spi_ram_mem #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 256
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [MEM_DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Callers guarantee addr_i < MEM_DEPTH whenever we_i or re_i is set.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/spi_ram_burst.sv
// Command decoder between the SPI slave rx side and its tx shifter: addressed
// writes into a RAM and multi-word read bursts with tx_ready backpressure.
module spi_ram_burst
    import spi_ram_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 256,
    parameter int BURST_W   = 4,
    parameter int AUTO_INC  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W+1:0] din,
    input  logic              rx_valid,
    input  logic              tx_ready,
    output logic [DATA_W-1:0] dout,
    output logic              tx_valid,
    output logic              busy,
    output logic              cmd_drop,
    output logic              addr_err
);

    localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W+1)'(MEM_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_C    = ADDR_W'(MEM_DEPTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [BURST_W:0]  BURST_ONE = (BURST_W+1)'(1);

    state_e            state_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [BURST_W:0]  remaining_q;
    logic              tx_valid_q;
    logic              busy_q;
    logic              cmd_drop_q;
    logic              addr_err_q;
    logic              zero_q;

    op_e               op;
    logic [DATA_W-1:0] payload;
    logic              accept;
    logic              wr_in_range;
    logic              rd_in_range;
    logic              load;
    logic              finish;
    logic              mem_we;
    logic              mem_re;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        if (AUTO_INC == 0) begin
            return a;
        end
        return (a == LAST_C) ? '0 : a + ADDR_ONE;
    endfunction

    assign op          = op_e'(din[DATA_W+1:DATA_W]);
    assign payload     = din[DATA_W-1:0];
    assign accept      = rx_valid && (state_q == IDLE);
    assign wr_in_range = ({1'b0, wr_addr_q} < DEPTH_C);
    assign rd_in_range = ({1'b0, rd_addr_q} < DEPTH_C);
    assign load        = (state_q == BURST) && (!tx_valid_q || tx_ready) && (remaining_q != '0);
    assign finish      = (state_q == BURST) && (remaining_q == '0) && tx_valid_q && tx_ready;

    // Writes only happen in IDLE and reads only in BURST, so one port suffices.
    assign mem_we   = accept && (op == OP_WR_DATA) && wr_in_range;
    assign mem_re   = load && rd_in_range;
    assign mem_addr = (state_q == BURST) ? rd_addr_q : wr_addr_q;

    spi_ram_mem #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .MEM_DEPTH(MEM_DEPTH)
    ) u_mem (
        .clk    (clk),
        .we_i   (mem_we),
        .re_i   (mem_re),
        .addr_i (mem_addr),
        .wdata_i(payload),
        .rdata_o(mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_addr_q   <= '0;
            rd_addr_q   <= '0;
            remaining_q <= '0;
            tx_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            cmd_drop_q  <= 1'b0;
            addr_err_q  <= 1'b0;
            zero_q      <= 1'b1;
        end else begin
            cmd_drop_q <= rx_valid && busy_q;
            addr_err_q <= (accept && (op == OP_WR_DATA) && !wr_in_range) ||
                          (load && !rd_in_range);
            case (state_q)
                IDLE: begin
                    if (rx_valid) begin
                        case (op)
                            OP_WR_ADDR: wr_addr_q <= payload[ADDR_W-1:0];
                            OP_WR_DATA: wr_addr_q <= next_addr(wr_addr_q);
                            OP_RD_ADDR: rd_addr_q <= payload[ADDR_W-1:0];
                            OP_RD_DATA: begin
                                remaining_q <= {1'b0, payload[BURST_W-1:0]} + BURST_ONE;
                                state_q     <= BURST;
                                busy_q      <= 1'b1;
                            end
                        endcase
                    end
                end
                BURST: begin
                    if (load) begin
                        // Out-of-range reads present zero instead of stale RAM output.
                        zero_q      <= !rd_in_range;
                        tx_valid_q  <= 1'b1;
                        remaining_q <= remaining_q - BURST_ONE;
                        rd_addr_q   <= next_addr(rd_addr_q);
                    end else if (finish) begin
                        tx_valid_q <= 1'b0;
                        busy_q     <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
            endcase
        end
    end

    assign dout     = zero_q ? '0 : mem_rdata;
    assign tx_valid = tx_valid_q;
    assign busy     = busy_q;
    assign cmd_drop = cmd_drop_q;
    assign addr_err = addr_err_q;

endmodule
